// File: rtl/sdm_pkg.sv
// rtl/sdm_pkg.sv - shared widths, feedback levels and saturation helper for the sigma-delta modulator
package sdm_pkg;

  // Default widths; the integrators carry two and four guard bits over the sample.
  localparam int DEF_DAC_BW = 16;
  localparam int DEF_I1_W   = DEF_DAC_BW + 2;
  localparam int DEF_I2_W   = DEF_DAC_BW + 4;

  // Wide working width for all sums before clamping; comfortably above any
  // integrator width so intermediate results never wrap.
  localparam int SAT_W = 48;

  // Feedback levels for the default sample width (+/- 2^(DAC_BW-1)).
  localparam logic signed [SAT_W-1:0] FB_POS = SAT_W'(32'sd1 <<< (DEF_DAC_BW - 1));
  localparam logic signed [SAT_W-1:0] FB_NEG = -FB_POS;

  // Feedback level for an arbitrary sample width: 1 -> +full-scale, 0 -> -full-scale.
  function automatic logic signed [SAT_W-1:0] feedback(input logic bit_i, input int unsigned bw);
    logic signed [SAT_W-1:0] mag;
    mag = SAT_W'(1) <<< (bw - 1);
    return bit_i ? mag : -mag;
  endfunction

  // Clamp a wide signed value to the signed range of a w-bit destination.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int unsigned w);
    logic signed [SAT_W-1:0] lim_hi;
    logic signed [SAT_W-1:0] lim_lo;
    lim_hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lim_lo = -lim_hi - SAT_W'(1);
    if (x > lim_hi) begin
      return lim_hi;
    end else if (x < lim_lo) begin
      return lim_lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/sdm_integrator.sv
// rtl/sdm_integrator.sv - saturating accumulator with load enable, exposing its next value
module sdm_integrator
  import sdm_pkg::*;
#(
  parameter int W = DEF_I1_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic signed [SAT_W-1:0] add_i,
  output logic signed [W-1:0]     acc_next_o
);

  logic signed [W-1:0]     acc_q;
  logic signed [W-1:0]     acc_d;
  logic signed [SAT_W-1:0] sum_w;
  logic signed [SAT_W-1:0] clamped_w;

  // Next accumulator value: widen, add, clamp back into W bits (never wraps).
  always_comb begin
    sum_w     = SAT_W'(acc_q) + add_i;
    clamped_w = sat(sum_w, W);
    acc_d     = clamped_w[W-1:0];
  end

  assign acc_next_o = acc_d;

  // Accumulator register; holds while the enable is low, clears on reset (active-high).
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sdm_modulator.sv
// rtl/sdm_modulator.sv - second-order single-bit sigma-delta modulator (PCM to 1-bit density stream)
module sdm_modulator
  import sdm_pkg::*;
#(
  parameter int DAC_BW = DEF_DAC_BW,
  parameter int I1_W   = DAC_BW + 2,
  parameter int I2_W   = DAC_BW + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DAC_BW-1:0] din,
  output logic                     valid_out,
  output logic                     dout
);

  logic                    dout_q;
  logic                    dout_d;
  logic                    valid_q;
  logic signed [SAT_W-1:0] fb_w;
  logic signed [SAT_W-1:0] add1_w;
  logic signed [SAT_W-1:0] add2_w;
  logic signed [I1_W-1:0]  i1_next_w;
  logic signed [I2_W-1:0]  i2_next_w;

  // Feedback from the registered bit, and the two integrator increments.
  // The second stage integrates the first stage's freshly clamped value.
  always_comb begin
    fb_w   = feedback(dout_q, DAC_BW);
    add1_w = SAT_W'(din) - fb_w;
    add2_w = SAT_W'(i1_next_w) - fb_w;
    dout_d = valid_in ? ~i2_next_w[I2_W-1] : dout_q;
  end

  sdm_integrator #(.W(I1_W)) u_int1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (valid_in),
    .add_i      (add1_w),
    .acc_next_o (i1_next_w)
  );

  sdm_integrator #(.W(I2_W)) u_int2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (valid_in),
    .add_i      (add2_w),
    .acc_next_o (i2_next_w)
  );

  // Quantiser output and valid flag; a gap in valid_in freezes the bit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_in;
    end
  end

  assign dout      = dout_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_sdm_modulator.sv
// tb/tb_sdm_modulator.sv - directed self-checking bench for sdm_modulator
module tb_sdm_modulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               valid_in = 1'b0;
  logic signed [15:0] din = '0;
  logic               valid_out;
  logic               dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdm_modulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout      (dout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic v, input logic signed [15:0] d);
    valid_in = v;
    din      = d;
    tick();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    int          ones;
    logic        prev;
    logic [63:0] ref_bits;
    logic [63:0] gap_bits;
    int          nv;

    // Reset held: clock and valid toggle, outputs stay cleared.
    for (int k = 0; k < 4; k++) begin
      apply(k[0], 16'sd16384);
      check("rst_hold_dout", 64'(dout), 64'd0);
      check("rst_hold_vout", 64'(valid_out), 64'd0);
    end

    // Zero input from power-up: 1,1,0 then 50% density.
    rst_n = 1'b0;
    apply(1'b0, 16'sd0);
    check("zero_idle_vout", 64'(valid_out), 64'd0);
    ones = 0;
    apply(1'b1, 16'sd0);
    check("zero_bit0", 64'(dout), 64'd1);
    check("zero_vout", 64'(valid_out), 64'd1);
    ones += int'(dout);
    apply(1'b1, 16'sd0);
    check("zero_bit1", 64'(dout), 64'd1);
    ones += int'(dout);
    apply(1'b1, 16'sd0);
    check("zero_bit2", 64'(dout), 64'd0);
    ones += int'(dout);
    for (int k = 3; k < 4096; k++) begin
      apply(1'b1, 16'sd0);
      ones += int'(dout);
    end
    check("zero_density", 64'(ones >= 2044 && ones <= 2052), 64'd1);

    // Positive half-scale, with an asynchronous reset mid-stream.
    reset_pulse();
    apply(1'b1, 16'sd16384);
    apply(1'b1, 16'sd16384);
    apply(1'b1, 16'sd16384);
    check("pos_pre_rst_dout", 64'(dout), 64'd1);
    check("pos_pre_rst_vout", 64'(valid_out), 64'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_dout", 64'(dout), 64'd0);
    check("async_rst_vout", 64'(valid_out), 64'd0);
    rst_n = 1'b0;
    ones = 0;
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 16'sd16384);
      check("pos_bit", 64'(dout), (k == 4) ? 64'd0 : 64'd1);
      ones += int'(dout);
    end
    for (int k = 5; k < 4096; k++) begin
      apply(1'b1, 16'sd16384);
      ones += int'(dout);
    end
    check("pos_density", 64'(ones >= 3068 && ones <= 3076), 64'd1);

    // Negative half-scale: valid_out follows valid_in by one cycle.
    reset_pulse();
    apply(1'b0, -16'sd16384);
    check("neg_idle_vout", 64'(valid_out), 64'd0);
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, -16'sd16384);
      check("neg_bit", 64'(dout), (k == 0 || k == 2) ? 64'd1 : 64'd0);
      ones += int'(dout);
    end
    check("neg_vout", 64'(valid_out), 64'd1);
    for (int k = 8; k < 4096; k++) begin
      apply(1'b1, -16'sd16384);
      ones += int'(dout);
    end
    check("neg_density", 64'(ones >= 1020 && ones <= 1028), 64'd1);

    // Negative full-scale: one startup 1, then solid 0 with no wrap glitches.
    reset_pulse();
    ones = 0;
    for (int k = 0; k < 1000; k++) begin
      apply(1'b1, -16'sd32768);
      ones += int'(dout);
    end
    check("negfs_ones", 64'(ones), 64'd1);
    check("negfs_last", 64'(dout), 64'd0);

    // Swing to positive full-scale: 0,0,0,0,1 then solid 1.
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 16'sd32767);
      check("posfs_recover", 64'(dout), (k == 4) ? 64'd1 : 64'd0);
    end
    ones = 0;
    for (int k = 0; k < 40; k++) begin
      apply(1'b1, 16'sd32767);
      ones += int'(dout);
    end
    check("posfs_ones", 64'(ones), 64'd40);

    // Gap-free reference run for din=-16384.
    reset_pulse();
    ref_bits = '0;
    for (int k = 0; k < 64; k++) begin
      apply(1'b1, -16'sd16384);
      ref_bits[k] = dout;
    end

    // Same input with gaps: valid cycles reproduce the reference, gaps hold.
    reset_pulse();
    gap_bits = '0;
    nv   = 0;
    prev = dout;
    for (int k = 0; k < 400 && nv < 64; k++) begin
      if ((k % 7) == 0 || (k % 7) == 2 || (k % 7) == 3 || (k % 7) == 5) begin
        apply(1'b1, -16'sd16384);
        check("gap_vout_hi", 64'(valid_out), 64'd1);
        gap_bits[nv] = dout;
        nv++;
      end else begin
        apply(1'b0, -16'sd16384);
        check("gap_vout_lo", 64'(valid_out), 64'd0);
        check("gap_hold", 64'(dout), 64'(prev));
      end
      prev = dout;
    end
    check("gap_count", 64'(nv), 64'd64);
    check("gap_seq_low", 64'(gap_bits[7:0]), 64'h05);
    check("gap_seq", gap_bits, ref_bits);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
